mem_dm_stage: RTL
=================

MEM_DM_STAGE -- requirements
Module: mem_dm_stage

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_Mem, input, 1, synchronous active-high reset.
REQ-003 SHALL have port memOp_Mem, input, 4, access type: 0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; 9-15 treated as none.
REQ-004 SHALL have port addr_Mem, input, 32, byte address (ALU result).
REQ-005 SHALL have port addrOv_Mem, input, 1, address-calculation overflow flag from Ex.
REQ-006 SHALL have port wd_Mem, input, 32, store data (forwarded rt).
REQ-007 SHALL have port kill_Mem, input, 1, instruction cancelled by interrupt/exception; suppresses every write.
REQ-008 SHALL have port devRd, input, 32, bridge read data.
REQ-009 SHALL have port dmRd_Mem, output, 32, extended load data, consumed by the Mem/Wb register.
REQ-010 SHALL have ports devAddr (output, 32), devWe (output, 1) and devWd (output, 32), the bridge write request.
REQ-011 SHALL have ports excValid_Mem (output, 1) and excCode_Mem (output, 5): 4 AdEL, 5 AdES, 0 none.

Function
REQ-012 SHALL hold a 3072-word data memory covering 0x0000_0000-0x0000_2FFF, word-indexed by addr_Mem[13:2].
REQ-013 SHALL decode device windows 0x7F00-0x7F0B (timer0) and 0x7F10-0x7F1B (timer1); every other address is unmapped.
REQ-014 SHALL raise AdEL on a load when: addrOv_Mem; lw with addr[1:0]!=0; lh/lhu with addr[0]!=0; lh/lhu/lb/lbu to a device; unmapped address.
REQ-015 SHALL raise AdES on a store under the same conditions, and also when the store targets a timer count register (offset 8).
REQ-016 SHALL evaluate exceptions combinationally in the same cycle; excCode_Mem SHALL be 0 when excValid_Mem is 0.
REQ-017 SHALL write the DM at the rising edge only when the op is a store, the address is in DM, there is no exception, and kill_Mem=0.
REQ-018 SHALL write byte lanes as follows: sw all four; sh lanes {1,0} or {3,2} selected by addr[1], data wd[15:0]; sb the single lane addr[1:0], data wd[7:0].
REQ-019 SHALL assert devWe for one cycle for a legal sw to a device with kill_Mem=0; devAddr=addr_Mem, devWd=wd_Mem.
REQ-020 SHALL provide an asynchronous read: dmRd_Mem reflects array contents before the same-edge write.
REQ-021 SHALL extend load data: lb/lh sign-extend, lbu/lhu zero-extend the selected lane; lw passes the word; device lw returns devRd.
REQ-022 SHALL drive dmRd_Mem=0 for non-loads and for excepting loads.
REQ-023 SHALL give a load in cycle N+1 the data of a store committed at the edge ending cycle N; no internal bypass is needed.

Reset
REQ-024 SHALL clear every DM word to 0 while reset_Mem is high at a clock edge; a store presented in the same cycle SHALL be discarded.
REQ-025 SHALL hold devWe=0 while reset_Mem is high; a mid-operation reset cancels any pending write with no partial lane update.

Structure
REQ-026 SHALL take memOp encodings, excCode values, address-map bounds and the DM depth from the shared CPU definitions package.
REQ-027 SHALL isolate the storage array (clear, byte-enable write, async read) in one sub-module, dm_ram; decode, exception and extension logic stay in mem_dm_stage.

Verification
REQ-028 SHALL cover a store-then-load: sw 0x12345678 @0x10, then lb @0x13 -> 0x00000012; lh @0x12 -> 0x00001234; lbu @0x10 -> 0x00000078.
REQ-029 SHALL cover sign extension: sb 0x80 @0x21, then lb @0x21 -> 0xFFFFFF80 and lbu @0x21 -> 0x00000080; the other lanes of word 0x20 stay unchanged.
REQ-030 SHALL cover misalignment: lw @0x6 -> AdEL, dmRd=0; sh @0x5 -> AdES with the memory unchanged.
REQ-031 SHALL cover device accesses: sw @0x7F04 -> devWe=1 for one cycle; sw @0x7F08 -> AdES with devWe=0; lb @0x7F00 -> AdEL.
REQ-032 SHALL cover kill and reset: sw with kill_Mem=1 -> no write; reset_Mem pulse after writes -> all probed words read 0.
REQ-033 SHALL cover address overflow and unmapped addresses: addrOv_Mem=1 on lw -> AdEL; sw @0x3000 -> AdES.

Source files
------------

// File: rtl/mem_dm_stage_pkg.sv
// Shared CPU definitions used by the memory stage: access types, exception
// codes, address map and data-memory geometry.
package mem_dm_stage_pkg;

  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LW   = 4'd1,
    MOP_LH   = 4'd2,
    MOP_LHU  = 4'd3,
    MOP_LB   = 4'd4,
    MOP_LBU  = 4'd5,
    MOP_SW   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SB   = 4'd8
  } mem_op_e;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam int unsigned DM_WORDS = 3072;
  localparam int unsigned DM_IDX_W = 12;

  localparam logic [31:0] DM_LO     = 32'h0000_0000;
  localparam logic [31:0] DM_HI     = 32'h0000_2FFF;
  localparam logic [31:0] TIMER0_LO = 32'h0000_7F00;
  localparam logic [31:0] TIMER0_HI = 32'h0000_7F0B;
  localparam logic [31:0] TIMER1_LO = 32'h0000_7F10;
  localparam logic [31:0] TIMER1_HI = 32'h0000_7F1B;

  // Word offset of the read-only count register inside a timer window.
  localparam logic [1:0] TIMER_COUNT_WORD = 2'd2;

endpackage

// File: rtl/dm_ram.sv
// Data-memory storage: synchronous clear, byte-enable write, async read.
module dm_ram
  import mem_dm_stage_pkg::*;
#(
  parameter int unsigned DEPTH = DM_WORDS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [3:0]          be,
  input  logic [DM_IDX_W-1:0] idx,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata
);

  localparam logic [DM_IDX_W-1:0] LAST_IDX = DM_IDX_W'(DEPTH - 1);

  logic [31:0] mem [DEPTH];

  // Clear everything on reset, otherwise commit the enabled byte lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i[DM_IDX_W-1:0]] <= '0;
      end
    end else if (we && idx <= LAST_IDX) begin
      if (be[0]) mem[idx][7:0]   <= wdata[7:0];
      if (be[1]) mem[idx][15:8]  <= wdata[15:8];
      if (be[2]) mem[idx][23:16] <= wdata[23:16];
      if (be[3]) mem[idx][31:24] <= wdata[31:24];
    end
  end

  // Asynchronous read; indices past the array read as zero.
  always_comb begin
    rdata = '0;
    if (idx <= LAST_IDX) rdata = mem[idx];
  end

endmodule

// File: rtl/mem_dm_stage.sv
// Memory stage: address decode, alignment/map exceptions, DM and device
// write requests, and load-data extension.
module mem_dm_stage
  import mem_dm_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_Mem,
  input  logic [3:0]  memOp_Mem,
  input  logic [31:0] addr_Mem,
  input  logic        addrOv_Mem,
  input  logic [31:0] wd_Mem,
  input  logic        kill_Mem,
  input  logic [31:0] devRd,
  output logic [31:0] dmRd_Mem,
  output logic [31:0] devAddr,
  output logic        devWe,
  output logic [31:0] devWd,
  output logic        excValid_Mem,
  output logic [4:0]  excCode_Mem
);

  logic        is_load, is_store, is_word, is_half, is_byte, is_signed;
  logic        in_dm, in_dev, exc;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata, ram_rd, src_word;
  logic [15:0] sel_half;
  logic [7:0]  sel_byte;

  // Classify the access type; unused encodings behave as no access.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_word   = 1'b0;
    is_half   = 1'b0;
    is_byte   = 1'b0;
    is_signed = 1'b0;
    case (memOp_Mem)
      MOP_LW:  begin is_load  = 1'b1; is_word = 1'b1; end
      MOP_LH:  begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      MOP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
      MOP_LB:  begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      MOP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
      MOP_SW:  begin is_store = 1'b1; is_word = 1'b1; end
      MOP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
      MOP_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
      default: ;
    endcase
  end

  // Address map decode and exception detection.
  always_comb begin
    in_dm  = (addr_Mem >= DM_LO) && (addr_Mem <= DM_HI);
    in_dev = ((addr_Mem >= TIMER0_LO) && (addr_Mem <= TIMER0_HI)) ||
             ((addr_Mem >= TIMER1_LO) && (addr_Mem <= TIMER1_HI));
    exc = 1'b0;
    if (is_load || is_store) begin
      if (addrOv_Mem)                          exc = 1'b1;
      if (is_word && addr_Mem[1:0] != 2'b00)   exc = 1'b1;
      if (is_half && addr_Mem[0])              exc = 1'b1;
      if (!is_word && in_dev)                  exc = 1'b1;
      if (!in_dm && !in_dev)                   exc = 1'b1;
      if (is_store && in_dev && addr_Mem[3:2] == TIMER_COUNT_WORD) exc = 1'b1;
    end
    excValid_Mem = exc;
    excCode_Mem  = EXC_NONE;
    if (exc) excCode_Mem = is_load ? EXC_ADEL : EXC_ADES;
  end

  // Write requests: lane enables and lane-replicated data for the DM, and
  // the word-only device write.
  always_comb begin
    dm_be    = 4'b0000;
    dm_wdata = wd_Mem;
    if (is_word) begin
      dm_be = 4'b1111;
    end else if (is_half) begin
      dm_be    = addr_Mem[1] ? 4'b1100 : 4'b0011;
      dm_wdata = {2{wd_Mem[15:0]}};
    end else if (is_byte) begin
      dm_wdata = {4{wd_Mem[7:0]}};
      case (addr_Mem[1:0])
        2'd0:    dm_be = 4'b0001;
        2'd1:    dm_be = 4'b0010;
        2'd2:    dm_be = 4'b0100;
        default: dm_be = 4'b1000;
      endcase
    end
    dm_we   = is_store && in_dm && !exc && !kill_Mem && !reset_Mem;
    devWe   = is_store && is_word && in_dev && !exc && !kill_Mem && !reset_Mem;
    devAddr = addr_Mem;
    devWd   = wd_Mem;
  end

  dm_ram #(.DEPTH(DM_WORDS)) u_dm_ram (
    .clk   (clk),
    .rst   (reset_Mem),
    .we    (dm_we),
    .be    (dm_be),
    .idx   (addr_Mem[13:2]),
    .wdata (dm_wdata),
    .rdata (ram_rd)
  );

  // Lane selection and sign/zero extension of load data.
  always_comb begin
    src_word = in_dev ? devRd : ram_rd;
    sel_half = addr_Mem[1] ? src_word[31:16] : src_word[15:0];
    case (addr_Mem[1:0])
      2'd0:    sel_byte = src_word[7:0];
      2'd1:    sel_byte = src_word[15:8];
      2'd2:    sel_byte = src_word[23:16];
      default: sel_byte = src_word[31:24];
    endcase
    dmRd_Mem = '0;
    if (is_load && !exc) begin
      if (is_word)      dmRd_Mem = src_word;
      else if (is_half) dmRd_Mem = {{16{is_signed & sel_half[15]}}, sel_half};
      else              dmRd_Mem = {{24{is_signed & sel_byte[7]}}, sel_byte};
    end
  end

endmodule
